// File: rtl/reservation_station_param_if.sv
// Dispatch, CDB snoop and issue signals of the ALU reservation station.
// master = dispatcher/CDB/ALU side, slave = the station itself.
interface reservation_station_param_if #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 3
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                      disp_valid, disp_ready;
  logic [OP_W-1:0]           disp_op;
  logic [1:0]                disp_src_en;
  logic [DATA_W-1:0]         disp_vj, disp_vk, disp_imm, disp_pc;
  logic [TAG_W-1:0]          disp_qj, disp_qk, disp_dest;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      iss_valid, iss_ready;
  logic [OP_W-1:0]           iss_op;
  logic [DATA_W-1:0]         iss_imm, iss_pc, iss_rs1, iss_rs2;
  logic [TAG_W-1:0]          iss_dest;
  logic [IDX_W:0]            occupancy;

  modport master (
    output disp_valid, disp_op, disp_src_en, disp_vj, disp_vk, disp_imm, disp_pc,
           disp_qj, disp_qk, disp_dest, cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_op, iss_imm, iss_pc, iss_rs1, iss_rs2,
           iss_dest, occupancy
  );
  modport slave (
    input  disp_valid, disp_op, disp_src_en, disp_vj, disp_vk, disp_imm, disp_pc,
           disp_qj, disp_qk, disp_dest, cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_op, iss_imm, iss_pc, iss_rs1, iss_rs2,
           iss_dest, occupancy
  );
endinterface

// File: rtl/reservation_station_param.sv
// Tomasulo reservation station for the ALU path: per-entry CDB snoop, one issue per cycle.
// Define RS_AGE_ORDER_EN for oldest-first select; otherwise lowest ready index issues.
module rs_entry #(
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 3,
  parameter logic [TAG_W-1:0] NULL_TAG = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      wr_i,
  input  logic                      clr_i,
  input  logic [OP_W-1:0]           op_i,
  input  logic [1:0]                src_en_i,
  input  logic [DATA_W-1:0]         vj_i, vk_i, imm_i, pc_i,
  input  logic [TAG_W-1:0]          qj_i, qk_i, dest_i,
  input  logic [NUM_CDB-1:0]        cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_i,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data_i,
  output logic                      busy_o,
  output logic                      ready_o,
  output logic [OP_W-1:0]           op_o,
  output logic [DATA_W-1:0]         vj_o, vk_o, imm_o, pc_o,
  output logic [TAG_W-1:0]          dest_o
);
  logic              busy_q;
  logic [1:0]        src_en_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] vj_q, vk_q, imm_q, pc_q, vj_d, vk_d;
  logic [TAG_W-1:0]  qj_q, qk_q, dest_q, qj_d, qk_d;

  // Descending scan so the lowest matching channel is the last to write.
  function automatic logic [TAG_W+DATA_W-1:0] resolve(input logic [TAG_W-1:0] q,
                                                      input logic [DATA_W-1:0] v);
    logic [TAG_W+DATA_W-1:0] r;
    r = {q, v};
    for (int c = NUM_CDB-1; c >= 0; c--)
      if (cdb_valid_i[c] && q != NULL_TAG && cdb_tag_i[c*TAG_W +: TAG_W] == q)
        r = {NULL_TAG, cdb_data_i[c*DATA_W +: DATA_W]};
    return r;
  endfunction

  always_comb begin
    {qj_d, vj_d} = wr_i ? resolve(qj_i, vj_i) : resolve(qj_q, vj_q);
    {qk_d, vk_d} = wr_i ? resolve(qk_i, vk_i) : resolve(qk_q, vk_q);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q   <= 1'b0;
      src_en_q <= '0;
      op_q     <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      dest_q   <= '0;
      vj_q     <= '0;
      vk_q     <= '0;
      qj_q     <= '0;
      qk_q     <= '0;
    end else begin
      if (flush_i)    busy_q <= 1'b0;
      else if (wr_i)  busy_q <= 1'b1;
      else if (clr_i) busy_q <= 1'b0;
      if (wr_i) begin
        src_en_q <= src_en_i;
        op_q     <= op_i;
        imm_q    <= imm_i;
        pc_q     <= pc_i;
        dest_q   <= dest_i;
      end
      vj_q <= vj_d;
      vk_q <= vk_d;
      qj_q <= qj_d;
      qk_q <= qk_d;
    end

  assign busy_o  = busy_q;
  assign ready_o = busy_q & (~src_en_q[0] | (qj_q == NULL_TAG))
                          & (~src_en_q[1] | (qk_q == NULL_TAG));
  assign op_o    = op_q;
  assign vj_o    = vj_q;
  assign vk_o    = vk_q;
  assign imm_o   = imm_q;
  assign pc_o    = pc_q;
  assign dest_o  = dest_q;
endmodule

module reservation_station_param #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 3,
  parameter logic [TAG_W-1:0] NULL_TAG = '0
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  reservation_station_param_if.slave rs
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [TAG_W-1:0]  dest;
  } iss_t;

  logic [DEPTH-1:0]             busy, ready, wr, clr, grant;
  logic [DEPTH-1:0][OP_W-1:0]   e_op;
  logic [DEPTH-1:0][DATA_W-1:0] e_vj, e_vk, e_imm, e_pc;
  logic [DEPTH-1:0][TAG_W-1:0]  e_dest;
  logic [IDX_W-1:0]             free_idx, sel_idx;
  logic                         disp_fire, any_ready, iss_load, iss_valid_q;
  logic [IDX_W:0]               occ;
  iss_t                         iss_q, iss_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rs_entry #(
      .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB), .NULL_TAG(NULL_TAG)
    ) u_ent (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .wr_i(wr[i]), .clr_i(clr[i]),
      .op_i(rs.disp_op), .src_en_i(rs.disp_src_en),
      .vj_i(rs.disp_vj), .vk_i(rs.disp_vk), .imm_i(rs.disp_imm), .pc_i(rs.disp_pc),
      .qj_i(rs.disp_qj), .qk_i(rs.disp_qk), .dest_i(rs.disp_dest),
      .cdb_valid_i(rs.cdb_valid), .cdb_tag_i(rs.cdb_tag), .cdb_data_i(rs.cdb_data),
      .busy_o(busy[i]), .ready_o(ready[i]), .op_o(e_op[i]),
      .vj_o(e_vj[i]), .vk_o(e_vk[i]), .imm_o(e_imm[i]), .pc_o(e_pc[i]), .dest_o(e_dest[i])
    );
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!busy[i]) free_idx = IDX_W'(i);
  end

  assign disp_fire = rs.disp_valid & ~(&busy) & ~flush;
  assign wr        = disp_fire ? (DEPTH'(1) << free_idx) : '0;

`ifdef RS_AGE_ORDER_EN
  // age_q[i][j] set means entry i is older than entry j.
  logic [DEPTH-1:0][DEPTH-1:0] age_q;

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (ready[j] && age_q[j][i]) grant[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age_q <= '0;
    else if (disp_fire)
      for (int i = 0; i < DEPTH; i++) begin
        age_q[free_idx][i] <= 1'b0;
        age_q[i][free_idx] <= busy[i];
      end
`else
  assign grant = ready & (~ready + DEPTH'(1));
`endif

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) sel_idx = IDX_W'(i);
  end

  assign any_ready = |ready;
  assign iss_load  = ~iss_valid_q | rs.iss_ready;
  assign clr       = (iss_load & ~flush) ? grant : '0;
  assign iss_d     = '{op: e_op[sel_idx], imm: e_imm[sel_idx], pc: e_pc[sel_idx],
                       rs1: e_vj[sel_idx], rs2: e_vk[sel_idx], dest: e_dest[sel_idx]};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
    end else if (flush) begin
      iss_valid_q <= 1'b0;
    end else if (iss_load) begin
      iss_valid_q <= any_ready;
      if (any_ready) iss_q <= iss_d;
    end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + (IDX_W+1)'(busy[i]);
  end

  assign rs.disp_ready = ~(&busy);
  assign rs.iss_valid  = iss_valid_q;
  assign rs.iss_op     = iss_q.op;
  assign rs.iss_imm    = iss_q.imm;
  assign rs.iss_pc     = iss_q.pc;
  assign rs.iss_rs1    = iss_q.rs1;
  assign rs.iss_rs2    = iss_q.rs2;
  assign rs.iss_dest   = iss_q.dest;
  assign rs.occupancy  = occ;
endmodule
